// File: rtl/if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS pipeline.
// Owns the PC, honours branch redirects and hazard-unit hold/flush, and counts held cycles.
module if_id_stage #(
    parameter int unsigned         PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pcHold,
    input  logic                 IFFlush,
    input  logic                 branchTaken,
    input  logic [PC_WIDTH-1:0]  branchTarget,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [0:31]          imem_rdata,
    output logic [0:31]          instr_ID,
    output logic [PC_WIDTH-1:0]  pcPlus4_ID,
    output logic                 valid_ID,
    output logic [0:5]           opCode_ID,
    output logic [0:4]           rs_ID,
    output logic [0:4]           rt_ID,
    output logic [0:4]           rd_ID,
    output logic [CNT_WIDTH-1:0] stallCount
);

    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic [PC_WIDTH-1:0]  pc_next;
    logic [0:31]          instr_next;
    logic [PC_WIDTH-1:0]  pc_plus4_id_next;
    logic                 valid_next;
    logic [CNT_WIDTH-1:0] stall_count_next;
    logic [1:0]           branch_offset_unused;

    // Redirect targets are word aligned; the low two bits carry no information.
    assign branch_offset_unused = branchTarget[1:0];

    assign pc_plus4  = pc + PC_WIDTH'(4);
    assign imem_addr = pc;

    assign opCode_ID = instr_ID[0:5];
    assign rs_ID     = instr_ID[6:10];
    assign rt_ID     = instr_ID[11:15];
    assign rd_ID     = instr_ID[16:20];

    // Next-state selection: branch beats hold/flush, which beat a plain fetch.
    always_comb begin
        pc_next          = pc;
        instr_next       = instr_ID;
        pc_plus4_id_next = pcPlus4_ID;
        valid_next       = valid_ID;
        stall_count_next = stallCount;

        if (branchTaken) begin
            pc_next          = {branchTarget[PC_WIDTH-1:2], 2'b00};
            instr_next       = '0;
            pc_plus4_id_next = '0;
            valid_next       = 1'b0;
        end else begin
            if (pcHold) begin
                if (stallCount != '1) begin
                    stall_count_next = stallCount + CNT_WIDTH'(1);
                end
            end else begin
                pc_next = pc_plus4;
            end

            if (IFFlush) begin
                instr_next       = '0;
                pc_plus4_id_next = '0;
                valid_next       = 1'b0;
            end else if (!pcHold) begin
                instr_next       = imem_rdata;
                pc_plus4_id_next = pc_plus4;
                valid_next       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            instr_ID   <= '0;
            pcPlus4_ID <= '0;
            valid_ID   <= 1'b0;
            stallCount <= '0;
        end else begin
            pc         <= pc_next;
            instr_ID   <= instr_next;
            pcPlus4_ID <= pc_plus4_id_next;
            valid_ID   <= valid_next;
            stallCount <= stall_count_next;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios then random traffic on two parameterisations,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst, pcHold, IFFlush, branchTaken;
    logic [31:0] branchTarget;

    logic [31:0] addr_a, p4_a, addr_b, p4_b;
    logic [0:31] rdata_a, instr_a, rdata_b, instr_b;
    logic        valid_a, valid_b;
    logic [0:5]  op_a, op_b;
    logic [0:4]  rs_a, rt_a, rd_a, rs_b, rt_b, rd_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    // Model state per instance: 0 = default parameters, 1 = wrap/saturation corner.
    logic [31:0] m_pc[2];
    logic [31:0] m_instr[2];
    logic [31:0] m_p4[2];
    logic        m_valid[2];
    int          m_cnt[2];
    logic [31:0] m_reset_pc[2] = '{32'h0, 32'hFFFF_FFFC};
    int          m_cnt_max[2]  = '{65535, 3};

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h8C22_0004;
            32'h4:   return 32'h0043_2020;
            default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
        endcase
    endfunction

    assign rdata_a = imem_fn(addr_a);
    assign rdata_b = imem_fn(addr_b);

    if_id_stage dut_a (
        .clk(clk), .rst(rst), .pcHold(pcHold), .IFFlush(IFFlush),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imem_addr(addr_a), .imem_rdata(rdata_a), .instr_ID(instr_a),
        .pcPlus4_ID(p4_a), .valid_ID(valid_a), .opCode_ID(op_a),
        .rs_ID(rs_a), .rt_ID(rt_a), .rd_ID(rd_a), .stallCount(cnt_a)
    );

    if_id_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .pcHold(pcHold), .IFFlush(IFFlush),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imem_addr(addr_b), .imem_rdata(rdata_b), .instr_ID(instr_b),
        .pcPlus4_ID(p4_b), .valid_ID(valid_b), .opCode_ID(op_b),
        .rs_ID(rs_b), .rt_ID(rt_b), .rd_ID(rd_b), .stallCount(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_bubble(input int i);
        m_instr[i] = 32'h0;
        m_p4[i]    = 32'h0;
        m_valid[i] = 1'b0;
    endtask

    // One clock of the fetch rules, written as the case table of the stage.
    task automatic model_step(input int i, input logic r, input logic b, input logic h,
                              input logic f, input logic [31:0] t);
        logic [31:0] fetched;
        logic [31:0] seq;
        fetched = imem_fn(m_pc[i]);
        seq     = m_pc[i] + 32'd4;
        if (r) begin
            m_pc[i]  = m_reset_pc[i];
            m_cnt[i] = 0;
            model_bubble(i);
        end else if (b) begin
            m_pc[i] = t & 32'hFFFF_FFFC;
            model_bubble(i);
        end else begin
            if (h && m_cnt[i] < m_cnt_max[i]) m_cnt[i]++;
            if (h && f) begin
                model_bubble(i);
            end else if (!h && f) begin
                m_pc[i] = seq;
                model_bubble(i);
            end else if (!h) begin
                m_pc[i]    = seq;
                m_instr[i] = fetched;
                m_p4[i]    = seq;
                m_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_inst(input int i, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] p4, input logic v, input logic [31:0] op,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] rd, input logic [31:0] cnt);
        check($sformatf("pc%0d", i),    pc,  m_pc[i]);
        check($sformatf("instr%0d", i), ins, m_instr[i]);
        check($sformatf("p4_%0d", i),   p4,  m_p4[i]);
        check($sformatf("valid%0d", i), {31'b0, v}, {31'b0, m_valid[i]});
        check($sformatf("op%0d", i),    op,  (m_instr[i] >> 26) & 32'h3F);
        check($sformatf("rs%0d", i),    rs,  (m_instr[i] >> 21) & 32'h1F);
        check($sformatf("rt%0d", i),    rt,  (m_instr[i] >> 16) & 32'h1F);
        check($sformatf("rd%0d", i),    rd,  (m_instr[i] >> 11) & 32'h1F);
        check($sformatf("cnt%0d", i),   cnt, 32'(m_cnt[i]));
    endtask

    task automatic step(input logic r, input logic b, input logic h, input logic f,
                        input logic [31:0] t);
        rst = r; branchTaken = b; pcHold = h; IFFlush = f; branchTarget = t;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_step(i, r, b, h, f, t);
        compare_inst(0, addr_a, instr_a, p4_a, valid_a, 32'(op_a), 32'(rs_a), 32'(rt_a),
                     32'(rd_a), 32'(cnt_a));
        compare_inst(1, addr_b, instr_b, p4_b, valid_b, 32'(op_b), 32'(rs_b), 32'(rt_b),
                     32'(rd_b), 32'(cnt_b));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0; m_cnt[i] = 0; model_bubble(i);
        end

        // T1: reset then first fetch from address 0
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t1_reset_pc", addr_a, 32'h0);
        check("t1_reset_valid", {31'b0, valid_a}, 32'h0);
        step(0, 0, 0, 0, 0);
        check("t1_instr", instr_a, 32'h8C22_0004);
        check("t1_p4", p4_a, 32'h4);
        check("t1_rs", 32'(rs_a), 32'd1);
        check("t1_rt", 32'(rt_a), 32'd2);
        check("t5_wrap", addr_b, 32'h0);

        // T2: load-use stall at pc 8
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        check("t2_pc", addr_a, 32'h8);
        check("t2_cnt", 32'(cnt_a), 32'd1);
        check("t2_valid", {31'b0, valid_a}, 32'h0);
        step(0, 0, 0, 0, 0);
        check("t2_resume", addr_a, 32'hC);

        // T6: hold-only keeps the IF/ID word
        step(0, 1, 0, 0, 32'h4);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t6_instr", instr_a, 32'h0043_2020);
        check("t6_valid", {31'b0, valid_a}, 32'h1);
        check("t6_pc", addr_a, 32'h8);

        // T3: two-cycle hold at 0x20
        step(0, 1, 0, 0, 32'h20);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t3_pc", addr_a, 32'h20);
        step(0, 0, 0, 0, 0);
        check("t3_p4", p4_a, 32'h24);

        // T4: branch beats hold; unaligned target
        step(0, 1, 1, 0, 32'h103);
        check("t4_pc", addr_a, 32'h100);
        check("t4_cnt", 32'(cnt_a), 32'd4);

        // Reset overrides branch and hold; then saturation of the narrow counter
        step(1, 1, 1, 1, 32'h40);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, k[0], 0);
        check("t5_sat", 32'(cnt_b), 32'd3);
        check("t5_cnt_wide", 32'(cnt_a), 32'd5);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = $urandom_range(0, 63);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
